// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, IF/ID register, one-entry skid buffer, redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_count / bubble_count outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   tgt_q;
    logic              req_q;
    logic [XLEN-1:0]   ir_q;
    logic [XLEN-1:0]   pc_q;
    logic              valid_q;
    logic              skid_full_q;
    logic [XLEN-1:0]   skid_ir_q;
    logic [XLEN-1:0]   skid_pc_q;

    logic              accept_c;
    logic              load_c;
    logic [XLEN-1:0]   tgt_c;
    logic [XLEN-1:0]   addr_inc_c;
    logic              unused_c;

    // A response only counts while we are actually requesting.
    assign accept_c   = imem_ready & req_q;
    assign tgt_c      = {redirect_pc[XLEN-1:2], 2'b00};
    assign addr_inc_c = addr_q + XLEN'(4);
    assign load_c     = ~redirect_in & (state_q == S_FETCH) & ~stall_in
                        & (skid_full_q | accept_c);
    assign unused_c   = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            addr_q      <= RESET_PC;
            tgt_q       <= RESET_PC;
            req_q       <= 1'b0;
            ir_q        <= NOP_INSTR;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
            skid_ir_q   <= '0;
            skid_pc_q   <= '0;
        end else if (redirect_in) begin
            // Flush wins over stall; an in-flight request must be drained first.
            ir_q        <= NOP_INSTR;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
            if (req_q && !imem_ready) begin
                state_q <= S_DROP;
                tgt_q   <= tgt_c;
            end else begin
                state_q <= S_FETCH;
                addr_q  <= tgt_c;
                req_q   <= 1'b1;
            end
        end else if (state_q == S_DROP) begin
            valid_q <= 1'b0;
            if (accept_c) begin
                state_q <= S_FETCH;
                addr_q  <= tgt_q;
            end
        end else if (skid_full_q) begin
            if (!stall_in) begin
                ir_q        <= skid_ir_q;
                pc_q        <= skid_pc_q;
                valid_q     <= 1'b1;
                skid_full_q <= 1'b0;
                req_q       <= 1'b1;
            end
        end else if (accept_c) begin
            addr_q <= addr_inc_c;
            if (stall_in) begin
                skid_ir_q   <= imem_rdata;
                skid_pc_q   <= addr_q;
                skid_full_q <= 1'b1;
                req_q       <= 1'b0;
            end else begin
                ir_q    <= imem_rdata;
                pc_q    <= addr_q;
                valid_q <= 1'b1;
            end
        end else begin
            req_q <= 1'b1;
            // Decoder consumed the current entry; nothing new arrived.
            if (!stall_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir_out    = ir_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] bubble_cnt_q;
    logic            started_q;

    // Bubbles are counted only once the first instruction has been delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            started_q    <= 1'b0;
        end else begin
            if (load_c) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
                started_q   <= 1'b1;
            end
            if (started_q && !valid_q) begin
                bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    logic unused_load_c;
    assign unused_load_c = load_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: wait-state memory responder, program-order scoreboard and directed scenarios.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        stall_in    = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready  = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int checks   = 0;
    int errors   = 0;
    int mem_wait = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_in    (stall_in),
        .redirect_in (redirect_in),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir_out      (ir_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .bubble_count(bubble_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h00A0_0093;
            32'h0000_1004: return 32'h0010_0113;
            32'h0000_1008: return 32'h0020_0193;
            32'h0000_100C: return 32'h0030_0213;
            default:       return a ^ 32'hC0DE_0003;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        rst_n       = 1'b0;
        stall_in    = 1'b0;
        redirect_in = 1'b0;
        redirect_pc = 32'h0;
        mem_wait    = w;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_for_pc(input logic [31:0] target, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (valid_out && pc_out == target) found = 1'b1;
        end
        chk("wait_for_pc", pc_out, target);
        if (!found && pc_out == target) begin
            errors++;
            $display("FAIL wait_for_pc: valid never rose for %h", target);
        end
    endtask

    // Memory: answers after mem_wait idle request cycles, with the addressed word.
    initial begin : memory
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                cnt        = 0;
                imem_ready = 1'b0;
            end else if (cnt >= mem_wait) begin
                cnt        = 0;
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                cnt++;
                imem_ready = 1'b0;
            end
        end
    end

    // Per-cycle scoreboard: handshake stability and in-order delivery of program-order PCs.
    initial begin : scoreboard
        logic        p_ok, p_req, p_ready, p_stall, p_redir, p_valid, flushing, ev;
        logic [31:0] p_addr, p_rpc, p_ir, p_pc, exp_pc;
        p_ok = 1'b0; p_req = 1'b0; p_ready = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        p_valid = 1'b0; flushing = 1'b0; ev = 1'b0;
        p_addr = '0; p_rpc = '0; p_ir = '0; p_pc = '0; exp_pc = RST_PC;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                p_ok     = 1'b0;
                exp_pc   = RST_PC;
                flushing = 1'b0;
            end else begin
                if (p_ok) begin
                    if (p_req && !p_ready) begin
                        chk("req_held", 32'(imem_req), 32'd1);
                        chk("addr_stable", imem_addr, p_addr);
                    end
                    if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                    ev = valid_out && (!p_valid || pc_out != p_pc);
                    if (p_redir) begin
                        chk("flush_valid", 32'(valid_out), 32'd0);
                        chk("flush_ir", ir_out, NOP);
                        exp_pc   = {p_rpc[31:2], 2'b00};
                        flushing = 1'b1;
                    end else begin
                        if (p_stall) begin
                            chk("stall_hold_ir", ir_out, p_ir);
                            chk("stall_hold_pc", pc_out, p_pc);
                            chk("stall_hold_valid", 32'(valid_out), 32'(p_valid));
                        end
                        if (p_req && p_ready && !p_stall && p_addr == exp_pc) begin
                            chk("latency_valid", 32'(valid_out), 32'd1);
                            chk("latency_pc", pc_out, p_addr);
                        end
                        if (ev) begin
                            chk("seq_pc", pc_out, exp_pc);
                            chk("seq_ir", ir_out, mem_word(pc_out));
                            exp_pc   = exp_pc + 32'd4;
                            flushing = 1'b0;
                        end else if (flushing) begin
                            chk("bubble_valid", 32'(valid_out), 32'd0);
                            chk("bubble_ir", ir_out, NOP);
                        end
                    end
                end
                p_ok = 1'b1; p_req = imem_req; p_ready = imem_ready; p_stall = stall_in;
                p_redir = redirect_in; p_valid = valid_out; p_addr = imem_addr;
                p_rpc = redirect_pc; p_ir = ir_out; p_pc = pc_out;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset values
        @(negedge clk);
        #1;
        chk("rst_ir", ir_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);

        // Zero-wait streaming
        do_reset(0);
        step();
        chk("t1_req_rise", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0000_1000);
        chk("t1_valid_low", 32'(valid_out), 32'd0);
        step();
        chk("t1_ir0", ir_out, 32'h00A0_0093);
        chk("t1_pc0", pc_out, 32'h0000_1000);
        chk("t1_valid0", 32'(valid_out), 32'd1);
        step();
        chk("t1_ir1", ir_out, 32'h0010_0113);
        chk("t1_pc1", pc_out, 32'h0000_1004);
        step();
        chk("t1_pc2", pc_out, 32'h0000_1008);
`ifdef FETCH_PERF_CNT_EN
        chk("t1_fetch_count", fetch_count, 32'd3);
        chk("t1_bubble_count", bubble_count, 32'd0);
`endif

        // Three wait cycles
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_addr_stable", imem_addr, 32'h0000_1000);
            chk("t2_req_high", 32'(imem_req), 32'd1);
        end
        step();
        chk("t2_pc0", pc_out, 32'h0000_1000);
        chk("t2_valid0", 32'(valid_out), 32'd1);
        repeat (4) step();
        chk("t2_pc1", pc_out, 32'h0000_1004);
        chk("t2_ir1", ir_out, 32'h0010_0113);

        // Stall while the 0x1008 word returns
        do_reset(0);
        repeat (3) step();
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_ir", ir_out, 32'h0010_0113);
            chk("t3_hold_pc", pc_out, 32'h0000_1004);
            chk("t3_req_low", 32'(imem_req), 32'd0);
        end
        stall_in = 1'b0;
        step();
        chk("t3_drain_ir", ir_out, 32'h0020_0193);
        chk("t3_drain_pc", pc_out, 32'h0000_1008);
        chk("t3_req_back", 32'(imem_req), 32'd1);
        chk("t3_next_addr", imem_addr, 32'h0000_100C);
        step();
        chk("t3_next_pc", pc_out, 32'h0000_100C);
        chk("t3_next_ir", ir_out, 32'h0030_0213);

        // Redirect with a request outstanding at 0x100C
        do_reset(2);
        repeat (10) step();
        chk("t4_pre_addr", imem_addr, 32'h0000_100C);
        redirect_in = 1'b1;
        redirect_pc = 32'h0000_2003;
        step();
        redirect_in = 1'b0;
        chk("t4_old_addr", imem_addr, 32'h0000_100C);
        chk("t4_flush_ir", ir_out, NOP);
        chk("t4_flush_valid", 32'(valid_out), 32'd0);
        repeat (2) step();
        chk("t4_new_addr", imem_addr, 32'h0000_2000);
        chk("t4_still_bubble", ir_out, NOP);
        wait_for_pc(32'h0000_2000, 10);
        chk("t4_target_ir", ir_out, 32'hC0DE_2003);

        // Redirect coincident with stall and ready
        do_reset(0);
        repeat (3) step();
        stall_in    = 1'b1;
        redirect_in = 1'b1;
        redirect_pc = 32'h0000_3000;
        step();
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        chk("t5_addr", imem_addr, 32'h0000_3000);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_valid", 32'(valid_out), 32'd0);
        chk("t5_ir", ir_out, NOP);
        step();
        chk("t5_pc", pc_out, 32'h0000_3000);
        chk("t5_target_ir", ir_out, 32'hC0DE_3003);

        // Reset mid-request
        do_reset(0);
        repeat (5) step();
        chk("t6_pre_addr", imem_addr, 32'h0000_1010);
        chk("t6_pre_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_ir", ir_out, NOP);
        chk("t6_pc", pc_out, 32'h0);
        chk("t6_valid", 32'(valid_out), 32'd0);
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_count", fetch_count, 32'd0);
        chk("t6_bubble_count", bubble_count, 32'd0);
`endif
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_restart_addr", imem_addr, 32'h0000_1000);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
